// File: rtl/cache_dm_wt.sv
// cache_dm_wt: direct-mapped, write-through, no-write-allocate word cache
// between a processor request port and a handshaked backing store.
//
// Ports:
//   clk, reset (async, active-low)
//   req_do/req_type/req_addr/req_data : processor request, sampled while busy=0
//   flush                             : one-cycle invalidate of every line
//   busy, O_data, req_done            : processor status / read data / completion
//   bs_req_do/type/addr/data          : backing-store request (one-cycle pulse)
//   bs_O_data, bs_req_done            : backing-store response
//   stat_hits, stat_misses            : lookup counters
//
// Build option: define CACHE_STATS_EN to implement the hit/miss counters;
// otherwise stat_hits and stat_misses are tied to 0.
module cache_dm_wt #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INDEX_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_do,
  input  logic              req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              flush,
  output logic              busy,
  output logic [DATA_W-1:0] O_data,
  output logic              req_done,
  output logic              bs_req_do,
  output logic              bs_req_type,
  output logic [ADDR_W-1:0] bs_req_addr,
  output logic [DATA_W-1:0] bs_req_data,
  input  logic [DATA_W-1:0] bs_O_data,
  input  logic              bs_req_done,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;
  localparam int unsigned LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_LOOKUP, S_BS_REQ, S_BS_WAIT, S_DONE
  } state_t;

  state_t state, state_next;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               accept;
  logic               lookup;
  logic               fill;
  logic               busy_d, req_done_d, bs_req_do_d;

  // Word-offset bits of the request address carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  // The latched request lives in the bs_req_* registers; index/tag come from there.
  assign idx    = bs_req_addr[INDEX_W+1:2];
  assign tag    = bs_req_addr[ADDR_W-1:INDEX_W+2];
  assign hit    = valid_q[idx] && (tag_mem[idx] == tag);
  assign accept = (state == S_IDLE) && !flush && req_do;
  assign lookup = (state == S_LOOKUP);
  assign fill   = (state == S_BS_WAIT) && bs_req_done && !bs_req_type;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (flush)       state_next = S_FLUSH;
        else if (req_do) state_next = S_LOOKUP;
      end
      S_FLUSH:   state_next = S_IDLE;
      S_LOOKUP:  state_next = (!bs_req_type && hit) ? S_DONE : S_BS_REQ;
      S_BS_REQ:  state_next = S_BS_WAIT;
      S_BS_WAIT: if (bs_req_done) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs track the state register
  always_comb begin
    busy_d      = (state_next != S_IDLE);
    req_done_d  = (state_next == S_DONE);
    bs_req_do_d = (state_next == S_BS_REQ);
  end

  // Control outputs, request latch, valid bits and read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy        <= 1'b0;
      req_done    <= 1'b0;
      bs_req_do   <= 1'b0;
      bs_req_type <= 1'b0;
      bs_req_addr <= '0;
      bs_req_data <= '0;
      O_data      <= '0;
      valid_q     <= '0;
    end else begin
      busy      <= busy_d;
      req_done  <= req_done_d;
      bs_req_do <= bs_req_do_d;
      if (accept) begin
        bs_req_type <= req_type;
        bs_req_addr <= {req_addr[ADDR_W-1:2], 2'b00};
        bs_req_data <= req_data;
      end
      if (state == S_FLUSH) valid_q <= '0;
      if (lookup && !bs_req_type && hit) O_data <= data_mem[idx];
      if (fill) begin
        valid_q[idx] <= 1'b1;
        O_data       <= bs_O_data;
      end
    end
  end

  // Tag/data arrays: write hits update in place, read misses refill the line
  always_ff @(posedge clk) begin
    if (lookup && bs_req_type && hit) data_mem[idx] <= bs_req_data;
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= bs_O_data;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  // Lookup counters; wrap naturally and survive flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (lookup) begin
      if (hit) hits_q   <= hits_q + 32'd1;
      else     misses_q <= misses_q + 32'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule

// File: doc/cache_dm_wt.md
Name: cache_dm_wt

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate word cache between the processor request port and a backing store.
- Generalises the single-set cache: configurable address, data and index widths, and a full write path.
- Adds an explicit busy handshake, a one-cycle whole-cache flush, and a handshaked backing-store master port.

Parameters:
- ADDR_W, 32, request address width in bits; bits [1:0] are the word offset and are ignored.
- DATA_W, 32, data word width.
- INDEX_W, 6, index bits; the cache has 2**INDEX_W lines, indexed by addr[INDEX_W+1:2]. Tag is addr[ADDR_W-1:INDEX_W+2], TAG_W = ADDR_W-INDEX_W-2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_do  in  1  request strobe; sampled only while busy=0.
- req_type  in  1  0 = read, 1 = write.
- req_addr  in  ADDR_W  request address.
- req_data  in  DATA_W  write data.
- flush  in  1  invalidate all lines; sampled only while busy=0.
- busy  out  1  high from the cycle after accept until req_done inclusive, and during the flush cycle.
- O_data  out  DATA_W  read data; valid while req_done=1 for a read; held until the next accept.
- req_done  out  1  one-cycle completion pulse.
- bs_req_do  out  1  one-cycle backing-store request pulse.
- bs_req_type  out  1  0 = read, 1 = write.
- bs_req_addr  out  ADDR_W  latched request address with [1:0] forced to 0.
- bs_req_data  out  DATA_W  latched write data.
- bs_O_data  in  DATA_W  backing-store read data; valid with bs_req_done.
- bs_req_done  in  1  backing-store completion pulse.
- stat_hits  out  32  hit counter (see Optional Feature).
- stat_misses  out  32  miss counter (see Optional Feature).

Behaviour:
- Line storage per line: valid, tag[TAG_W], data[DATA_W].
- Reset (reset=0, async):
  - state IDLE; all valid bits 0.
  - busy, req_done, bs_req_do, bs_req_type = 0.
  - O_data, bs_req_addr, bs_req_data = 0; counters 0.
  - Reset mid-transaction abandons it; a late bs_req_done after reset is ignored.
- States: IDLE, FLUSH, LOOKUP, BS_REQ, BS_WAIT, DONE.
- IDLE:
  - flush=1: go to FLUSH. flush wins over a simultaneous req_do; that req_do is dropped.
  - Else req_do=1: latch addr, data and type, go to LOOKUP.
  - busy=0 only in IDLE.
- FLUSH: clear every valid bit in this cycle; next state IDLE.
- LOOKUP: hit = valid[idx] && tag[idx] == addr tag.
  - Read hit: O_data <= line data; go to DONE.
  - Read miss: go to BS_REQ.
  - Write hit: update line data; go to BS_REQ.
  - Write miss: line untouched; go to BS_REQ.
- BS_REQ: bs_req_do=1 for exactly one cycle, with bs_req_type/addr/data from the latched request; next state BS_WAIT.
- BS_WAIT: hold until bs_req_done=1.
  - Read: write {valid=1, tag, bs_O_data} into the line and O_data <= bs_O_data; go to DONE.
  - Write: go to DONE.
- bs_req_done in any other state is ignored.
- DONE: req_done=1 for one cycle; next state IDLE. A new req_do is accepted from the following cycle.
- Latency (accept edge = cycle 0):
  - Read hit: req_done in cycle 2.
  - Miss or write: bs_req_do in cycle 2; req_done 1 cycle after bs_req_done.
  - bs_req_done in cycle 3: req_done in cycle 4.
- Request inputs are don't-care after accept; only latched values are used.
- Index wrap: max index 2**INDEX_W-1 is a normal line. Aliasing addresses with equal index replace each other on a read miss.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - stat_hits increments in LOOKUP on every hit (read or write).
  - stat_misses increments in LOOKUP on every miss.
  - Both counters are 32-bit and wrap at 2**32-1 -> 0.
  - FLUSH does not clear them; only reset does.
- Undefined: no counter registers; stat_hits and stat_misses are tied to 0.

Test Plan:
- Reset, then read 0x0000_0104 with the backing store returning 0xDEADBEEF -> bs_req_do cycle 2, bs_req_addr=0x104; req_done with O_data=0xDEADBEEF; repeat read -> hit, req_done cycle 2, no bs_req_do.
- Read 0x104 (fill), then write 0x104 with data 0x12345678 -> bs write with bs_req_data=0x12345678; following read of 0x104 hits and returns 0x12345678.
- Write 0x208 on a cold cache, then read 0x208 -> write causes no allocation; read misses and issues bs_req_do with type 0.
- Fill 0x104, then read 0x1104 (same index 1, different tag) -> miss and refill; re-read 0x104 misses again.
- Fill lines, then pulse flush together with req_do -> req_do dropped, busy=1 for one cycle; next read of 0x104 misses.
- Assert reset=0 while in BS_WAIT, release, then drive bs_req_done=1 -> no req_done, all lines invalid, state IDLE. With CACHE_STATS_EN, a hit/miss sequence of 3 hits and 2 misses -> stat_hits=3, stat_misses=2.
